// File: rtl/cam_allocator_mt.sv
// Multi-type CU free-space CAM: per-CU, per-type free counts with valid bits,
// and a one-in-flight fit query returning a fit bitmap and a round-robin first-fit CU.
module cam_allocator_mt #(
  parameter int CU_ID_WIDTH   = 6,
  parameter int NUMBER_CU     = 64,
  parameter int RES_ID_WIDTH  = 10,
  parameter int NUM_RES_TYPES = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        search_valid,
  output logic                                        search_ready,
  input  logic [NUM_RES_TYPES*(RES_ID_WIDTH+1)-1:0]   search_size,
  input  logic [NUMBER_CU-1:0]                        search_cu_mask,
  output logic                                        result_valid,
  input  logic                                        result_ready,
  output logic [NUMBER_CU-1:0]                        result_bitmap,
  output logic                                        result_found,
  output logic [CU_ID_WIDTH-1:0]                      result_cu_id,
  input  logic                                        cam_wr_en,
  input  logic [CU_ID_WIDTH-1:0]                      cam_wr_addr,
  input  logic [NUM_RES_TYPES-1:0]                    cam_wr_type_en,
  input  logic [NUM_RES_TYPES*(RES_ID_WIDTH+1)-1:0]   cam_wr_data,
  input  logic                                        cam_inv_en
);

  localparam int W = RES_ID_WIDTH + 1;
  localparam int T = NUM_RES_TYPES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_SEL,
    ST_HOLD
  } state_t;

  state_t                 state_reg, state_next;
  logic [T*W-1:0]         size_reg;
  logic [NUMBER_CU-1:0]   mask_reg;
  logic [NUMBER_CU-1:0]   fit_now;
  logic [NUMBER_CU-1:0]   fit_reg;
  logic [CU_ID_WIDTH-1:0] rr_reg;
  logic [CU_ID_WIDTH-1:0] sel_id;
  logic                   accept;
  logic                   pop_found;

  // Per-CU table entry: free counts (no reset) plus per-type valid bits.
  // An invalid type field counts as fully free.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NUMBER_CU; gi++) begin : g_cu
      logic           wr_hit;
      logic [T-1:0]   vld_reg;
      logic [W-1:0]   cnt_reg [T];
      logic [T-1:0]   type_fit;

      assign wr_hit = (cam_wr_addr == CU_ID_WIDTH'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_reg <= '0;
        end else if (wr_hit) begin
          if (cam_inv_en)
            vld_reg <= '0;
          else if (cam_wr_en)
            vld_reg <= vld_reg | cam_wr_type_en;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_hit && cam_wr_en && !cam_inv_en) begin
          for (int k = 0; k < T; k++) begin
            if (cam_wr_type_en[k])
              cnt_reg[k] <= cam_wr_data[k*W +: W];
          end
        end
      end

      for (gk = 0; gk < T; gk++) begin : g_type
        assign type_fit[gk] = !vld_reg[gk] || (cnt_reg[gk] >= size_reg[gk*W +: W]);
      end

      assign fit_now[gi] = mask_reg[gi] & (&type_fit);
    end
  endgenerate

  // Round-robin first fit: lowest set bit at or above rr_reg, else lowest set bit overall.
  always_comb begin
    logic [CU_ID_WIDTH-1:0] pick_any;
    logic [CU_ID_WIDTH-1:0] pick_hi;
    logic                   hit_hi;
    pick_any = '0;
    pick_hi  = '0;
    hit_hi   = 1'b0;
    for (int i = NUMBER_CU - 1; i >= 0; i--) begin
      if (fit_reg[i]) begin
        pick_any = CU_ID_WIDTH'(i);
        if (CU_ID_WIDTH'(i) >= rr_reg) begin
          pick_hi = CU_ID_WIDTH'(i);
          hit_hi  = 1'b1;
        end
      end
    end
    sel_id = hit_hi ? pick_hi : pick_any;
  end

  always_comb begin
    state_next   = state_reg;
    search_ready = 1'b0;
    result_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        search_ready = 1'b1;
        if (search_valid)
          state_next = ST_CMP;
      end
      ST_CMP:  state_next = ST_SEL;
      ST_SEL:  state_next = ST_HOLD;
      ST_HOLD: begin
        result_valid = 1'b1;
        if (result_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept    = search_valid && search_ready;
  assign pop_found = result_valid && result_ready && result_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      size_reg      <= '0;
      mask_reg      <= '0;
      fit_reg       <= '0;
      result_bitmap <= '0;
      result_found  <= 1'b0;
      result_cu_id  <= '0;
      rr_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg <= search_size;
        mask_reg <= search_cu_mask;
      end
      // The bitmap is captured at the end of CMP, so writes landing on that edge are excluded.
      if (state_reg == ST_CMP)
        fit_reg <= fit_now;
      if (state_reg == ST_SEL) begin
        result_bitmap <= fit_reg;
        result_found  <= |fit_reg;
        result_cu_id  <= sel_id;
      end
      if (pop_found) begin
        if (result_cu_id == CU_ID_WIDTH'(NUMBER_CU - 1))
          rr_reg <= '0;
        else
          rr_reg <= result_cu_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_allocator_mt.sv
// Directed bench for cam_allocator_mt: latency, fit rules, round-robin selection,
// write/search ordering, hold stability and asynchronous reset.
module tb_cam_allocator_mt;

  localparam int CW = 6;
  localparam int NC = 64;
  localparam int RW = 10;
  localparam int NT = 4;
  localparam int W  = RW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              search_valid;
  logic              search_ready;
  logic [NT*W-1:0]   search_size;
  logic [NC-1:0]     search_cu_mask;
  logic              result_valid;
  logic              result_ready;
  logic [NC-1:0]     result_bitmap;
  logic              result_found;
  logic [CW-1:0]     result_cu_id;
  logic              cam_wr_en;
  logic [CW-1:0]     cam_wr_addr;
  logic [NT-1:0]     cam_wr_type_en;
  logic [NT*W-1:0]   cam_wr_data;
  logic              cam_inv_en;

  int errors = 0;
  int checks = 0;

  cam_allocator_mt #(
    .CU_ID_WIDTH(CW), .NUMBER_CU(NC), .RES_ID_WIDTH(RW), .NUM_RES_TYPES(NT)
  ) dut (
    .clk(clk), .rst(rst),
    .search_valid(search_valid), .search_ready(search_ready),
    .search_size(search_size), .search_cu_mask(search_cu_mask),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_bitmap(result_bitmap), .result_found(result_found),
    .result_cu_id(result_cu_id),
    .cam_wr_en(cam_wr_en), .cam_wr_addr(cam_wr_addr),
    .cam_wr_type_en(cam_wr_type_en), .cam_wr_data(cam_wr_data),
    .cam_inv_en(cam_inv_en)
  );

  always #5 clk = ~clk;

  function automatic logic [NT*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    search_valid = 1'b0; result_ready = 1'b0;
    cam_wr_en = 1'b0; cam_inv_en = 1'b0;
    cam_wr_addr = '0; cam_wr_type_en = '0; cam_wr_data = '0;
    search_size = '0; search_cu_mask = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_write(input int addr, input logic [NT-1:0] ten, input logic [NT*W-1:0] data);
    cam_wr_addr = CW'(addr); cam_wr_type_en = ten; cam_wr_data = data; cam_wr_en = 1'b1;
    tick();
    cam_wr_en = 1'b0;
  endtask

  // Drives a query and returns just after the accept edge (bounded wait for search_ready).
  task automatic start_query(input logic [NT*W-1:0] sz, input logic [NC-1:0] m);
    int n;
    n = 0;
    while (search_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL start_query_timeout: search_ready=%b required 1", search_ready);
    end
    search_size = sz; search_cu_mask = m; search_valid = 1'b1;
    tick();
    search_valid = 1'b0;
  endtask

  task automatic run_query(input logic [NT*W-1:0] sz, input logic [NC-1:0] m);
    start_query(sz, m);
    tick(); tick();
    $display("query mask=%h -> valid=%b bitmap=%h found=%b cu=%0d",
             m, result_valid, result_bitmap, result_found, result_cu_id);
  endtask

  task automatic pop();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (search_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", search_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    checks++; if (result_bitmap !== '0) begin errors++; $display("FAIL reset_bitmap: got %h want 0", result_bitmap); end
    checks++; if (result_found !== 1'b0 || result_cu_id !== '0) begin
      errors++; $display("FAIL reset_found_id: got %b/%0d want 0/0", result_found, result_cu_id); end
  endtask

  task automatic test_latency_all_invalid();
    apply_reset();
    start_query(pk(5, 5, 5, 5), {NC{1'b1}});
    checks++; if (result_valid !== 1'b0 || search_ready !== 1'b0) begin
      errors++; $display("FAIL lat_cmp: valid=%b ready=%b want 0/0", result_valid, search_ready); end
    tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: valid=%b want 0", result_valid); end
    tick();
    $display("query all-invalid -> valid=%b bitmap=%h found=%b cu=%0d",
             result_valid, result_bitmap, result_found, result_cu_id);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: valid=%b want 1", result_valid); end
    checks++; if (result_bitmap !== {NC{1'b1}}) begin errors++; $display("FAIL lat_bitmap: got %h want all ones", result_bitmap); end
    checks++; if (result_found !== 1'b1 || result_cu_id !== 6'd0) begin
      errors++; $display("FAIL lat_id: got %b/%0d want 1/0", result_found, result_cu_id); end
    pop();
    checks++; if (search_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL lat_pop: ready=%b valid=%b want 1/0", search_ready, result_valid); end
  endtask

  task automatic test_fit_compare();
    logic [NC-1:0] m3;
    apply_reset();
    m3 = '0; m3[3] = 1'b1;
    do_write(3, 4'b1111, pk(100, 8, 0, 4));
    run_query(pk(50, 8, 1, 4), m3);
    checks++; if (result_bitmap !== '0 || result_found !== 1'b0 || result_cu_id !== 6'd0) begin
      errors++; $display("FAIL fit_type2: bitmap=%h found=%b id=%0d want 0/0/0", result_bitmap, result_found, result_cu_id); end
    pop();
    run_query(pk(100, 8, 0, 4), m3);
    checks++; if (result_bitmap !== m3 || result_found !== 1'b1 || result_cu_id !== 6'd3) begin
      errors++; $display("FAIL fit_equal: bitmap=%h found=%b id=%0d want %h/1/3", result_bitmap, result_found, result_cu_id, m3); end
    pop();
    run_query(pk(101, 0, 0, 0), m3);
    checks++; if (result_found !== 1'b0) begin errors++; $display("FAIL fit_over: found=%b want 0", result_found); end
    pop();
    // Same-cycle invalidate and write: invalidate wins, entry becomes fully free.
    cam_inv_en = 1'b1;
    do_write(3, 4'b1111, pk(0, 0, 0, 0));
    cam_inv_en = 1'b0;
    run_query(pk(2047, 2047, 2047, 2047), m3);
    checks++; if (result_bitmap !== m3 || result_cu_id !== 6'd3) begin
      errors++; $display("FAIL inv_wins: bitmap=%h id=%0d want %h/3", result_bitmap, result_cu_id, m3); end
    pop();
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] m, exp_bm;
    apply_reset();
    m = '0; m[2] = 1'b1; m[5] = 1'b1; m[9] = 1'b1;
    exp_bm = '0; exp_bm[2] = 1'b1; exp_bm[5] = 1'b1;
    do_write(2, 4'b0001, pk(20, 0, 0, 0));
    do_write(5, 4'b0001, pk(30, 0, 0, 0));
    do_write(9, 4'b0001, pk(5, 0, 0, 0));
    run_query(pk(10, 0, 0, 0), m);
    checks++; if (result_bitmap !== exp_bm || result_cu_id !== 6'd2) begin
      errors++; $display("FAIL rr_first: bitmap=%h id=%0d want %h/2", result_bitmap, result_cu_id, exp_bm); end
    pop();
    run_query(pk(10, 0, 0, 0), m);
    checks++; if (result_cu_id !== 6'd5) begin errors++; $display("FAIL rr_second: id=%0d want 5", result_cu_id); end
    pop();
    run_query(pk(10, 0, 0, 0), m);
    checks++; if (result_cu_id !== 6'd2) begin errors++; $display("FAIL rr_wrap: id=%0d want 2", result_cu_id); end
    pop();
  endtask

  task automatic test_write_ordering();
    logic [NC-1:0] m7;
    m7 = '0; m7[7] = 1'b1;
    apply_reset();
    // Write coincides with the accept edge: visible to the query.
    cam_wr_addr = 6'd7; cam_wr_type_en = 4'b0001; cam_wr_data = pk(0, 0, 0, 0); cam_wr_en = 1'b1;
    search_size = pk(1, 0, 0, 0); search_cu_mask = m7; search_valid = 1'b1;
    tick();
    cam_wr_en = 1'b0; search_valid = 1'b0;
    tick(); tick();
    $display("query accept-edge write -> bitmap=%h found=%b", result_bitmap, result_found);
    checks++; if (result_valid !== 1'b1 || result_found !== 1'b0) begin
      errors++; $display("FAIL wr_accept_edge: valid=%b found=%b want 1/0", result_valid, result_found); end
    pop();
    apply_reset();
    start_query(pk(1, 0, 0, 0), m7);
    do_write(7, 4'b0001, pk(0, 0, 0, 0));
    tick();
    $display("query cmp-cycle write -> bitmap=%h found=%b cu=%0d", result_bitmap, result_found, result_cu_id);
    checks++; if (result_found !== 1'b1 || result_cu_id !== 6'd7) begin
      errors++; $display("FAIL wr_in_cmp: found=%b id=%0d want 1/7", result_found, result_cu_id); end
    pop();
    run_query(pk(1, 0, 0, 0), m7);
    checks++; if (result_found !== 1'b0) begin errors++; $display("FAIL wr_cmp_landed: found=%b want 0", result_found); end
    pop();
  endtask

  task automatic test_hold_stable();
    logic [NC-1:0] m2;
    int bad;
    m2 = '0; m2[2] = 1'b1;
    apply_reset();
    run_query(pk(10, 0, 0, 0), m2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cam_wr_addr = 6'd2; cam_wr_type_en = 4'b0001; cam_wr_data = pk(0, 0, 0, 0); cam_wr_en = 1'b1;
        search_valid = 1'b1; search_size = pk(0, 0, 0, 0); search_cu_mask = '1;
      end
      if (i == 4) begin
        cam_wr_en = 1'b0; search_valid = 1'b0;
      end
      tick();
      checks++;
      if (result_valid !== 1'b1 || search_ready !== 1'b0 || result_bitmap !== m2 ||
          result_found !== 1'b1 || result_cu_id !== 6'd2) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b bitmap=%h id=%0d want 1/0/%h/2",
                 i, result_valid, search_ready, result_bitmap, result_cu_id, m2);
      end
    end
    pop();
    run_query(pk(10, 0, 0, 0), m2);
    checks++; if (result_found !== 1'b0) begin errors++; $display("FAIL hold_write_landed: found=%b want 0", result_found); end
    pop();
  endtask

  task automatic test_reset_mid_query();
    logic [NC-1:0] m;
    m = '0; m[2] = 1'b1; m[5] = 1'b1;
    apply_reset();
    run_query(pk(1, 1, 1, 1), m);
    checks++; if (result_cu_id !== 6'd2) begin errors++; $display("FAIL rst_pre: id=%0d want 2", result_cu_id); end
    pop();
    start_query(pk(1, 1, 1, 1), m);
    #2 rst = 1'b1;
    #1;
    $display("async reset during CMP -> valid=%b ready=%b", result_valid, search_ready);
    checks++; if (result_valid !== 1'b0 || search_ready !== 1'b1 || result_bitmap !== '0) begin
      errors++; $display("FAIL rst_async: valid=%b ready=%b bitmap=%h want 0/1/0", result_valid, search_ready, result_bitmap); end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_dropped: valid=%b want 0", result_valid); end
    run_query(pk(1, 1, 1, 1), m);
    checks++; if (result_cu_id !== 6'd2) begin errors++; $display("FAIL rst_rrptr: id=%0d want 2", result_cu_id); end
    pop();
  endtask

  initial begin
    test_reset();
    test_latency_all_invalid();
    test_fit_compare();
    test_round_robin();
    test_write_ordering();
    test_hold_stable();
    test_reset_mid_query();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
